sensor_dma_reader: RTL and testbench
====================================

SENSOR_DMA_READER -- requirements
Module: sensor_dma_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, SHALL set the output FIFO depth in 32-bit words (power of two, >=16).
REQ-002 Parameter MAX_BURST, default 16, SHALL set the maximum beats per AXI read burst (ARLEN 4-bit, 1..16).
REQ-003 Ports SHALL be, clock and reset first (name dir width meaning):
  s_axi_aclk_IBUF_BUFG  in  1  single clock; all logic rising-edge
  s_axi_aresetn_IBUF  in  1  asynchronous active-low reset
  start  in  1  one-cycle request to begin a transfer
  base_addr  in  62  start word address (byte address [63:2])
  num_words  in  16  transfer length in 32-bit words
  busy  out  1  transfer in progress
  done  out  1  one-cycle completion pulse
  error  out  1  sticky: any RRESP!=OKAY in current transfer
  m_axi_gmem_ARADDR  out  62  burst word address [63:2]
  m_axi_gmem_ARLEN  out  4  beats minus one
  m_axi_gmem_ARVALID  out  1  address valid
  m_axi_gmem_ARREADY  in  1  address accepted
  m_axi_gmem_RDATA  in  32  read data
  m_axi_gmem_RRESP  in  2  read response
  m_axi_gmem_RLAST  in  1  last beat of burst
  m_axi_gmem_RVALID  in  1  read data valid
  m_axi_gmem_RREADY  out  1  read data accepted
  out_data  out  32  word to accelerator core
  out_valid  out  1  out_data valid
  out_ready  in  1  core accepts word

Function
REQ-004 FSM states SHALL be IDLE, ADDR, DATA, FINISH.
REQ-005 IDLE: start=1 SHALL latch base_addr, num_words, clear error, go to ADDR (FINISH if num_words=0); busy=1 from next cycle.
REQ-006 start while busy SHALL be ignored.
REQ-007 Burst length SHALL be min(MAX_BURST, remaining words, words to next 4 KB boundary = 1024 - addr[9:0]).
REQ-008 ADDR: ARVALID=1 with ARADDR/ARLEN stable until ARREADY=1; on handshake go to DATA, advance address by burst length.
REQ-009 ADDR SHALL NOT assert ARVALID unless FIFO free space >= burst length.
REQ-010 DATA: RREADY SHALL equal FIFO-not-full; each RVALID&RREADY beat SHALL push RDATA into FIFO and decrement remaining.
REQ-011 On beat with RLAST=1: remaining>0 and error=0 -> ADDR; else -> FINISH.
REQ-012 RRESP!=2'b00 on any beat SHALL set error; current burst SHALL still be drained; no further bursts issued.
REQ-013 FINISH: done=1 for exactly one cycle, busy=0 from next cycle, return to IDLE; done does not wait for FIFO drain.
REQ-014 FIFO SHALL be first-word-fall-through: out_valid=!empty, out_data=head; pop on out_valid&out_ready.
REQ-015 Simultaneous push and pop SHALL keep occupancy constant; push when full impossible (RREADY=0).
REQ-016 Only one burst outstanding at a time; ARVALID never asserted in DATA.

Reset
REQ-017 Reset low SHALL asynchronously force IDLE, busy=0, done=0, error=0, ARVALID=0, RREADY=0, out_valid=0, FIFO empty, address/counters 0.
REQ-018 Reset mid-transfer SHALL discard FIFO contents and in-flight burst; no done pulse after release.

Structure
REQ-019 Shared package SHALL hold FSM state enum, MAX_BURST, BOUNDARY_WORDS=1024, RESP_OKAY=2'b00.
REQ-020 FIFO SHALL be sub-module dma_sync_fifo (parameterised width/depth, count output).

Verification
REQ-021 start, base=0x400, num=20, ARREADY=1, memory returns incrementing data -> bursts (0x400,ARLEN=15),(0x410,ARLEN=3); 20 words out in order; one done.
REQ-022 base=0x3FA, num=16 -> bursts (0x3FA,ARLEN=5),(0x400,ARLEN=9); no burst crosses 4 KB.
REQ-023 num=0 -> no ARVALID; done one cycle after start; error=0.
REQ-024 num=32, out_ready=0 -> 16 words buffered, RREADY=0 when full, no second AR; out_ready=1 -> remaining 16 fetched, total 32 out.
REQ-025 num=32, beat 3 RRESP=2'b10 -> error=1, first burst drained (16 words pushed), no second AR, done pulses.
REQ-026 reset asserted mid-DATA of num=32 -> outputs at reset values immediately; after release, new start num=4 -> exactly 4 words, one done.

Source files
------------

// File: rtl/sensor_dma_reader_pkg.sv
// Shared definitions for the sensor DMA reader: FSM state encoding,
// burst and boundary constants, and the burst-length helper.
package sensor_dma_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_DATA   = 2'd2,
    ST_FINISH = 2'd3
  } dma_state_t;

  localparam int         MAX_BURST      = 16;
  localparam int         BOUNDARY_WORDS = 1024;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  // Beats for the next burst: smallest of the burst cap, the words still to
  // fetch and the words left before the next 4 KB boundary.
  function automatic logic [4:0] burst_len(input logic [15:0] remaining,
                                           input logic [9:0]  addr_lo,
                                           input logic [4:0]  max_burst);
    logic [10:0] bound;
    logic [4:0]  len;
    bound = 11'(BOUNDARY_WORDS) - {1'b0, addr_lo};
    len   = max_burst;
    if (remaining < {11'b0, len}) len = remaining[4:0];
    if (bound < {6'b0, len})      len = bound[4:0];
    return len;
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports: clk/rst_n, i_push/i_data write side, i_pop read side,
// o_data (head word), o_empty, o_full, o_count (occupancy).
module dma_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sensor_dma_reader.sv
// AXI read master that fetches num_words 32-bit words from base_addr in
// 4 KB-safe bursts and streams them to the core through a FWFT FIFO.
// Ports: clock/reset, start/base_addr/num_words command, busy/done/error
// status, AXI AR and R channels (m_axi_gmem_*), out_data/out_valid/out_ready.
//
// state  | meaning
// IDLE   | waiting for start
// ADDR   | waiting for FIFO room, then presenting the burst address
// DATA   | receiving beats of the single outstanding burst
// FINISH | one-cycle done pulse, then back to IDLE
module sensor_dma_reader
  import sensor_dma_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = sensor_dma_reader_pkg::MAX_BURST
) (
  input  logic        s_axi_aclk_IBUF_BUFG,
  input  logic        s_axi_aresetn_IBUF,
  input  logic        start,
  input  logic [61:0] base_addr,
  input  logic [15:0] num_words,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [61:0] m_axi_gmem_ARADDR,
  output logic [3:0]  m_axi_gmem_ARLEN,
  output logic        m_axi_gmem_ARVALID,
  input  logic        m_axi_gmem_ARREADY,
  input  logic [31:0] m_axi_gmem_RDATA,
  input  logic [1:0]  m_axi_gmem_RRESP,
  input  logic        m_axi_gmem_RLAST,
  input  logic        m_axi_gmem_RVALID,
  output logic        m_axi_gmem_RREADY,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_t  r_state;
  logic [61:0] r_addr;
  logic [15:0] r_remaining;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_arvalid;
  logic [3:0]  r_arlen;

  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic [4:0]    w_len;
  logic [16:0]   w_free;
  logic          w_rbeat;
  logic          w_resp_err;
  logic [15:0]   w_rem_dec;

  assign w_len      = burst_len(r_remaining, r_addr[9:0], 5'(MAX_BURST));
  assign w_free     = 17'(FIFO_DEPTH) - 17'(w_count);
  assign w_rbeat    = m_axi_gmem_RVALID && m_axi_gmem_RREADY;
  assign w_resp_err = (m_axi_gmem_RRESP != RESP_OKAY);
  assign w_rem_dec  = r_remaining - 16'd1;

  assign busy               = r_busy;
  assign done               = r_done;
  assign error              = r_error;
  assign m_axi_gmem_ARADDR  = r_addr;
  assign m_axi_gmem_ARLEN   = r_arlen;
  assign m_axi_gmem_ARVALID = r_arvalid;
  assign m_axi_gmem_RREADY  = (r_state == ST_DATA) && !w_full;
  assign out_valid          = !w_empty;

  dma_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (s_axi_aclk_IBUF_BUFG),
    .rst_n   (s_axi_aresetn_IBUF),
    .i_push  (w_rbeat),
    .i_data  (m_axi_gmem_RDATA),
    .i_pop   (out_ready),
    .o_data  (out_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  always_ff @(posedge s_axi_aclk_IBUF_BUFG or negedge s_axi_aresetn_IBUF) begin
    if (!s_axi_aresetn_IBUF) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_arvalid   <= 1'b0;
      r_arlen     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= num_words;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            if (num_words == 16'd0) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          // Only one burst is in flight, so FIFO free space can only grow
          // here; once the burst fits, ARVALID is raised and held.
          if (r_arvalid) begin
            if (m_axi_gmem_ARREADY) begin
              r_arvalid <= 1'b0;
              r_addr    <= r_addr + 62'(r_arlen) + 62'd1;
              r_state   <= ST_DATA;
            end
          end else if (w_free >= 17'(w_len)) begin
            r_arvalid <= 1'b1;
            r_arlen   <= 4'(w_len - 5'd1);
          end
        end
        ST_DATA: begin
          if (w_rbeat) begin
            r_remaining <= w_rem_dec;
            if (w_resp_err) r_error <= 1'b1;
            if (m_axi_gmem_RLAST) begin
              if ((w_rem_dec != 16'd0) && !r_error && !w_resp_err) begin
                r_state <= ST_ADDR;
              end else begin
                r_state <= ST_FINISH;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_dma_reader.sv
module tb_sensor_dma_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [61:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy, done, error;
  logic [61:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  always #5 clk = ~clk;

  sensor_dma_reader #(.FIFO_DEPTH(16), .MAX_BURST(16)) dut (
    .s_axi_aclk_IBUF_BUFG (clk),
    .s_axi_aresetn_IBUF   (rst_n),
    .start                (start),
    .base_addr            (base_addr),
    .num_words            (num_words),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .m_axi_gmem_ARADDR    (araddr),
    .m_axi_gmem_ARLEN     (arlen),
    .m_axi_gmem_ARVALID   (arvalid),
    .m_axi_gmem_ARREADY   (arready),
    .m_axi_gmem_RDATA     (rdata),
    .m_axi_gmem_RRESP     (rresp),
    .m_axi_gmem_RLAST     (rlast),
    .m_axi_gmem_RVALID    (rvalid),
    .m_axi_gmem_RREADY    (rready),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [61:0] addr;
    logic [3:0]  len;
  } ar_t;

  typedef struct {
    logic [61:0] base;
    logic [15:0] num;
    int          err_beat;
    int          ar_stall;
    int          nb;
    logic [61:0] ba [3];
    logic [3:0]  bl [3];
    logic        exp_err;
    int          nwords;
  } vec_t;

  ar_t         ar_exp_q [$];
  logic [31:0] word_q [$];

  int          n_ar = 0, n_words = 0, n_done = 0, n_beats = 0;
  int          err_beat = -1;
  int          ar_stall = 0;
  int          ar_wait = 0;
  logic        err_at_done = 1'b0;
  logic        in_burst = 1'b0;
  logic [61:0] b_addr = '0;
  int          b_left = 0;
  logic        prev_ar_wait = 1'b0;
  logic [61:0] prev_araddr = '0;
  logic [3:0]  prev_arlen = '0;

  function automatic logic [31:0] mem_word(input logic [61:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    total++;
    bad++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // AXI slave model and output monitor: observe at negedge, drive at posedge+1
  initial begin
    ar_t         e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_burst = 1'b0;
        b_left = 0;
        ar_wait = 0;
        prev_ar_wait = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          n_words++;
          if (word_q.size() == 0) fail("word_unexpected", $sformatf("got %0h expected none", out_data));
          else begin
            w = word_q.pop_front();
            check("out_data", out_data, w);
          end
        end
        if (done) begin
          n_done++;
          err_at_done = error;
        end
        if (prev_ar_wait) begin
          check("ar_hold_valid", arvalid, 1);
          check("ar_hold_addr", araddr, prev_araddr);
          check("ar_hold_len", arlen, prev_arlen);
        end
        prev_ar_wait = arvalid && !arready;
        prev_araddr = araddr;
        prev_arlen = arlen;
        if (arvalid && !arready) ar_wait++;
        if (rvalid && rready) begin
          n_beats++;
          b_addr = b_addr + 62'd1;
          b_left--;
          if (b_left == 0) in_burst = 1'b0;
        end
        if (arvalid && arready) begin
          n_ar++;
          ar_wait = 0;
          if (in_burst) fail("ar_outstanding", "second AR while a burst is in flight");
          if (ar_exp_q.size() == 0) fail("ar_unexpected", $sformatf("got addr %0h len %0d expected none", araddr, arlen));
          else begin
            e = ar_exp_q.pop_front();
            check("ar_addr", araddr, e.addr);
            check("ar_len", arlen, e.len);
          end
          in_burst = 1'b1;
          b_addr = araddr;
          b_left = int'(arlen) + 1;
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
      end else begin
        arready = (ar_stall == 0) ? 1'b1 : (arvalid && ar_wait >= ar_stall);
        rvalid = in_burst && (b_left > 0);
        rdata = mem_word(b_addr);
        rlast = (b_left == 1);
        rresp = (n_beats == err_beat) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic clear_sb();
    ar_exp_q.delete();
    word_q.delete();
    n_ar = 0;
    n_words = 0;
    n_done = 0;
    n_beats = 0;
  endtask

  task automatic push_ar(input logic [61:0] a, input logic [3:0] l);
    ar_t t;
    t.addr = a;
    t.len = l;
    ar_exp_q.push_back(t);
  endtask

  task automatic push_words(input logic [61:0] b, input int cnt);
    for (int i = 0; i < cnt; i++) word_q.push_back(mem_word(b + 62'(i)));
  endtask

  task automatic do_start(input logic [61:0] b, input logic [15:0] n);
    @(posedge clk);
    #1;
    base_addr = b;
    num_words = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while (!(n_done >= 1 && !busy && !out_valid) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) fail(name, "timeout waiting for completion");
    repeat (10) @(negedge clk);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{62'h400, 16'd20, -1, 0, 2, '{62'h400, 62'h410, 62'h0}, '{4'd15, 4'd3, 4'd0}, 1'b0, 20};
    vecs[1] = '{62'h3FA, 16'd16, -1, 2, 2, '{62'h3FA, 62'h400, 62'h0}, '{4'd5, 4'd9, 4'd0}, 1'b0, 16};
    vecs[2] = '{62'h000, 16'd0, -1, 0, 0, '{62'h0, 62'h0, 62'h0}, '{4'd0, 4'd0, 4'd0}, 1'b0, 0};
    vecs[3] = '{62'h400, 16'd32, 2, 0, 1, '{62'h400, 62'h0, 62'h0}, '{4'd15, 4'd0, 4'd0}, 1'b1, 16};
    vecs[4] = '{62'h7FF, 16'd5, -1, 1, 2, '{62'h7FF, 62'h800, 62'h0}, '{4'd0, 4'd3, 4'd0}, 1'b0, 5};
    vecs[5] = '{62'h010, 16'd3, -1, 0, 1, '{62'h010, 62'h0, 62'h0}, '{4'd2, 4'd0, 4'd0}, 1'b0, 3};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven transfers
    for (int v = 0; v < 6; v++) begin
      clear_sb();
      err_beat = vecs[v].err_beat;
      ar_stall = vecs[v].ar_stall;
      out_ready = 1'b1;
      for (int b = 0; b < vecs[v].nb; b++) push_ar(vecs[v].ba[b], vecs[v].bl[b]);
      push_words(vecs[v].base, vecs[v].nwords);
      do_start(vecs[v].base, vecs[v].num);
      wait_idle($sformatf("v%0d_wait", v), 2000);
      check($sformatf("v%0d_done_count", v), n_done, 1);
      check($sformatf("v%0d_ar_count", v), n_ar, vecs[v].nb);
      check($sformatf("v%0d_words", v), n_words, vecs[v].nwords);
      check($sformatf("v%0d_err_at_done", v), err_at_done, vecs[v].exp_err);
      check($sformatf("v%0d_err_sticky", v), error, vecs[v].exp_err);
    end
    err_beat = -1;
    ar_stall = 0;

    // num=0: done exactly one cycle after start, no AR
    clear_sb();
    do_start(62'h123, 16'd0);
    @(negedge clk);
    check("zero_done_hi", done, 1);
    check("zero_busy_hi", busy, 1);
    @(negedge clk);
    check("zero_done_lo", done, 0);
    check("zero_busy_lo", busy, 0);
    repeat (5) @(negedge clk);
    check("zero_ar_count", n_ar, 0);
    check("zero_error", error, 0);

    // backpressure: FIFO fills, second AR waits, start while busy ignored
    clear_sb();
    out_ready = 1'b0;
    push_ar(62'h400, 4'd15);
    push_ar(62'h410, 4'd15);
    push_words(62'h400, 32);
    do_start(62'h400, 16'd32);
    repeat (60) @(negedge clk);
    check("bp_beats", n_beats, 16);
    check("bp_rready", rready, 0);
    check("bp_ar_count", n_ar, 1);
    check("bp_out_valid", out_valid, 1);
    check("bp_busy", busy, 1);
    do_start(62'h7000, 16'd5);
    repeat (5) @(negedge clk);
    check("bp_ignored_start", n_ar, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("bp_wait", 2000);
    check("bp_done_count", n_done, 1);
    check("bp_words", n_words, 32);
    check("bp_ar_total", n_ar, 2);

    // reset mid-DATA, then a fresh short transfer
    clear_sb();
    push_ar(62'h400, 4'd15);
    push_ar(62'h410, 4'd15);
    push_words(62'h400, 32);
    do_start(62'h400, 16'd32);
    for (int c = 0; c < 200 && n_beats < 5; c++) @(negedge clk);
    if (n_beats < 5) fail("mr_wait", "timeout waiting for beats");
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_error", error, 0);
    check("mr_arvalid", arvalid, 0);
    check("mr_araddr", araddr, 0);
    check("mr_rready", rready, 0);
    check("mr_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_sb();
    repeat (5) @(negedge clk);
    check("mr_no_done", n_done, 0);
    check("mr_no_ar", n_ar, 0);
    push_ar(62'h020, 4'd3);
    push_words(62'h020, 4);
    do_start(62'h020, 16'd4);
    wait_idle("mr2_wait", 2000);
    check("mr2_done_count", n_done, 1);
    check("mr2_words", n_words, 4);
    check("mr2_ar_count", n_ar, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
